// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Combinational conditional absolute value: negates val_i when neg_en_i and its MSB are set.
module seq_mult_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_en_i,
    output logic [WIDTH-1:0] mag_o
);

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        mag_o = val_i;
        if (neg_en_i && val_i[WIDTH-1]) begin
            mag_o = -val_i;
        end
    end

endmodule

// File: rtl/seq_mult_param.sv
// Radix-2 sequential shift-add multiplier, one operation in flight, valid/ready on both sides.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   o,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_chk
        $error("seq_mult_param: WIDTH must lie in 2..32");
    end

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [PW-1:0]     o_q, o_d;

    logic              signed_act;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [PW-1:0]     acc_next;

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    assign signed_act = SIGNED_EN ? signed_mode : 1'b0;

    seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
        .val_i    (a),
        .neg_en_i (signed_act),
        .mag_o    (mag_a)
    );

    seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
        .val_i    (b),
        .neg_en_i (signed_act),
        .mag_o    (mag_b)
    );

    assign acc_next = acc_q + (mag_b_q[0] ? mcand_q : '0);

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mag_b_d = mag_b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        o_d     = o_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = {{WIDTH{1'b0}}, mag_a};
                    mag_b_d = mag_b;
                    neg_d   = signed_act & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                mcand_d = mcand_q << 1;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    o_d     = apply_sign(acc_next, neg_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mag_b_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mag_b_q <= mag_b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            o_q     <= o_d;
        end
    end

    // Handshake outputs decode the state register only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign o         = o_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: four instances (W4, W8, W16, W8 unsigned-only) against an arithmetic product model.
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid_s[4];
    logic        out_ready_s[4];
    logic        sm_s[4];
    logic [31:0] a_s[4];
    logic [31:0] b_s[4];

    logic        in_ready_w[4];
    logic        out_valid_w[4];
    logic        busy_w[4];
    logic [7:0]  o0;
    logic [15:0] o1;
    logic [31:0] o2;
    logic [15:0] o3;

    int width_t[4] = '{4, 8, 16, 8};
    bit sen_t[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    seq_mult_param #(.WIDTH(4), .SIGNED_EN(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s[0][3:0]), .b(b_s[0][3:0]), .signed_mode(sm_s[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .o(o0), .busy(busy_w[0]));

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .signed_mode(sm_s[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .o(o1), .busy(busy_w[1]));

    seq_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
        .a(a_s[2][15:0]), .b(b_s[2][15:0]), .signed_mode(sm_s[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]), .o(o2), .busy(busy_w[2]));

    seq_mult_param #(.WIDTH(8), .SIGNED_EN(1'b0)) u_w8u (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[3]), .in_ready(in_ready_w[3]),
        .a(a_s[3][7:0]), .b(b_s[3][7:0]), .signed_mode(sm_s[3]),
        .out_valid(out_valid_w[3]), .out_ready(out_ready_s[3]), .o(o3), .busy(busy_w[3]));

    function automatic logic [63:0] get_o(input int id);
        case (id)
            0:       return 64'(o0);
            1:       return 64'(o1);
            2:       return 64'(o2);
            default: return 64'(o3);
        endcase
    endfunction

    // Golden product: interpret operands as plain integers and multiply.
    function automatic logic [63:0] model(input int w, input bit sen, input logic [31:0] a,
                                          input logic [31:0] b, input bit sm);
        longint m1, sa, sb, p;
        m1 = (longint'(1) << w) - 1;
        sa = longint'(a) & m1;
        sb = longint'(b) & m1;
        if (sen && sm) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (!in_ready_w[id] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(in_ready_w[id]), 64'd1);
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b, input bit sm,
                          input int hold, input bit strict, output logic [63:0] res);
        int w;
        int lat;
        logic [63:0] exp;
        logic [63:0] held;
        w   = width_t[id];
        exp = model(w, sen_t[id], a, b, sm);
        wait_idle(id);
        in_valid_s[id]  = 1'b1;
        a_s[id]         = a;
        b_s[id]         = b;
        sm_s[id]        = sm;
        out_ready_s[id] = 1'b0;
        @(posedge clk); #1;
        in_valid_s[id] = 1'b0;
        a_s[id]        = $urandom;
        b_s[id]        = $urandom;
        sm_s[id]       = 1'($urandom_range(0, 1));
        if (strict) chk("busy_run", 64'(busy_w[id]), 64'd1);
        lat = 0;
        while (!out_valid_w[id] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency_id%0d", id), 64'(lat), 64'(w));
        chk($sformatf("product_id%0d", id), get_o(id), exp);
        res  = get_o(id);
        held = res;
        for (int k = 0; k < hold; k++) begin
            if (strict) begin
                in_valid_s[id] = 1'b1;
                a_s[id]        = $urandom;
                b_s[id]        = $urandom;
            end
            @(posedge clk); #1;
            if (strict) begin
                chk("hold_valid", 64'(out_valid_w[id]), 64'd1);
                chk("hold_o", get_o(id), held);
                chk("hold_in_ready", 64'(in_ready_w[id]), 64'd0);
            end
        end
        in_valid_s[id]  = 1'b0;
        out_ready_s[id] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[id] = 1'b0;
        chk("release_in_ready", 64'(in_ready_w[id]), 64'd1);
        chk("release_out_valid", 64'(out_valid_w[id]), 64'd0);
    endtask

    task automatic burst(input int id, input int nacc);
        logic [63:0] q[$];
        int w, last, accs, guard;
        w = width_t[id];
        last = -1;
        accs = 0;
        guard = 0;
        out_ready_s[id] = 1'b1;
        in_valid_s[id]  = 1'b1;
        a_s[id] = $urandom;
        b_s[id] = $urandom;
        sm_s[id] = 1'($urandom_range(0, 1));
        while (accs < nacc && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (out_valid_w[id]) begin
                if (q.size() > 0) chk("burst_o", get_o(id), q.pop_front());
                else chk("burst_extra_valid", 64'(out_valid_w[id]), 64'd0);
            end
            if (in_ready_w[id]) begin
                if (last >= 0) chk("initiation_interval", 64'(cyc - last), 64'(w + 2));
                last = cyc;
                q.push_back(model(w, sen_t[id], a_s[id], b_s[id], sm_s[id]));
                accs++;
            end else begin
                a_s[id]  = $urandom;
                b_s[id]  = $urandom;
                sm_s[id] = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        in_valid_s[id] = 1'b0;
        while (q.size() > 0 && guard < 6000) begin
            @(negedge clk);
            guard++;
            if (out_valid_w[id]) chk("burst_o", get_o(id), q.pop_front());
        end
        if (guard >= 5000) chk("burst_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        out_ready_s[id] = 1'b0;
    endtask

    initial begin
        logic [63:0] res;
        int seen;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0; sm_s[i] = 1'b0;
            a_s[i] = '0; b_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_o", get_o(i), 64'd0);
            chk("reset_out_valid", 64'(out_valid_w[i]), 64'd0);
            chk("reset_in_ready", 64'(in_ready_w[i]), 64'd1);
            chk("reset_busy", 64'(busy_w[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(0, 32'd15, 32'd15, 1'b0, 0, 1'b1, res);
        chk("w4_15x15", res, 64'hE1);
        run_op(1, 32'h80, 32'h80, 1'b1, 0, 1'b1, res);
        chk("s8_m128_sq", res, 64'h4000);
        run_op(1, 32'hFD, 32'h05, 1'b1, 0, 1'b1, res);
        chk("s8_m3x5", res, 64'hFFF1);
        run_op(1, 32'h80, 32'h7F, 1'b1, 0, 1'b1, res);
        chk("s8_m128x127", res, 64'hC080);

        run_op(1, 32'h12, 32'h34, 1'b0, 6, 1'b1, res);

        // Abort mid-RUN with asynchronous reset.
        wait_idle(1);
        in_valid_s[1] = 1'b1; a_s[1] = 32'd9; b_s[1] = 32'd9; sm_s[1] = 1'b0;
        @(posedge clk); #1;
        in_valid_s[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_o", get_o(1), 64'd0);
        chk("abort_out_valid", 64'(out_valid_w[1]), 64'd0);
        chk("abort_in_ready", 64'(in_ready_w[1]), 64'd1);
        chk("abort_busy", 64'(busy_w[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid_w[1]) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        run_op(1, 32'd3, 32'd7, 1'b0, 0, 1'b1, res);
        chk("after_abort_3x7", res, 64'd21);

        run_op(1, 32'd0, 32'hFF, 1'b0, 0, 1'b1, res);
        chk("zero_unsigned", res, 64'd0);
        run_op(1, 32'd0, 32'hFF, 1'b1, 0, 1'b1, res);
        chk("zero_signed", res, 64'd0);

        run_op(3, 32'hFD, 32'h05, 1'b1, 0, 1'b1, res);
        chk("unsigned_only_253x5", res, 64'h04F1);

        for (int id = 0; id < 4; id++) burst(id, 12);

        for (int i = 0; i < 1000; i++) begin
            int id, w;
            logic [31:0] ra, rb, m;
            id = i % 4;
            w  = width_t[id];
            m  = 32'((64'd1 << w) - 64'd1);
            ra = $urandom & m;
            rb = $urandom & m;
            if ($urandom_range(0, 7) == 0) ra = 32'd1 << (w - 1);
            if ($urandom_range(0, 7) == 0) rb = m;
            run_op(id, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, res);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential radix-2 shift-add multiplier with per-operation signed/unsigned selection. It replaces the fixed 4-bit free-running multiplier. It sits behind a valid/ready request port and a valid/ready result port, so it can be chained into datapath pipelines or driven by a controller FSM. One operation is in flight at a time, and the result is held until the consumer accepts it.

## Interface
- WIDTH, 8, operand width in bits; legal range 2 to 32; product width is 2*WIDTH.
- SIGNED_EN, 1, when 0 the signed path is removed and signed_mode is ignored (treated as 0).
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- a  input  WIDTH  multiplicand, sampled on accept.
- b  input  WIDTH  multiplier, sampled on accept.
- signed_mode  input  1  1 means a and b are two's complement; sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- o  output  2*WIDTH  product; registered; stable while out_valid is high.
- busy  output  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:** in_ready=1.
  - On in_valid&&in_ready, latch mag_a=|a| and mag_b=|b| if the signed path is active; otherwise latch raw a and b.
  - Latch neg = a[W-1]^b[W-1] when signed, else 0.
  - Clear the accumulator acc (2W bits) and the counter cnt, then go to RUN.
- **RUN:** each cycle:
  - If mag_b[0], acc += mcand, where mcand is 2W bits, zero-extended mag_a.
  - Then mcand <<= 1, mag_b >>= 1, cnt++.
  - On the iteration where cnt==WIDTH-1, register o = neg ? -(acc_next) : acc_next (2W-bit two's complement), then go to DONE.
- **DONE:** out_valid=1 and o is held. On out_ready, go to IDLE.
  - No new request is accepted in the same cycle, because in_ready=0 in DONE.
- **Arithmetic:**
  - Magnitudes are WIDTH-bit unsigned. |-2^(W-1)| = 2^(W-1) fits without overflow.
  - The maximum product magnitude is 2^(2W-2) (signed) or (2^W-1)^2 (unsigned); both fit in 2W bits. No saturation is needed.
- **Zero operand:** runs the full WIDTH iterations (fixed latency) and o=0.
  - Negative zero cannot occur, because -0 = 0.
- **Inputs outside IDLE:** a, b and signed_mode may change freely; only the values at accept matter.
- **Reset (any state, including mid-RUN):**
  - state=IDLE, o=0, out_valid=0, busy=0, in_ready=1, acc=0, cnt=0.
  - An aborted operation produces no out_valid.

## Timing
- Accept occurs at clock edge E0. RUN spans edges E1..EWIDTH. o is updated and out_valid rises after edge EWIDTH.
- Latency from accept to out_valid is WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles, assuming out_ready is held high: WIDTH RUN cycles, 1 DONE cycle, then 1 IDLE cycle.
- in_ready, out_valid and busy are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- o changes only on the edge that enters DONE, or on reset.

## Structure
- The shared package seq_mult_pkg holds:
  - the state enum (IDLE, RUN, DONE; 2 bits);
  - the counter-width function clog2(WIDTH);
  - the constants MIN_WIDTH=2 and MAX_WIDTH=32.
- A WIDTH range check is an elaboration-time assertion.
- One sub-module, seq_mult_abs, is natural: a combinational WIDTH-bit conditional two's-complement absolute value. It is instantiated twice for a and b.
- The final negate stays inline.

## Test plan
- **Unsigned, WIDTH=4:** a=15, b=15, signed_mode=0 -> o=225 (0xE1), out_valid exactly 4 cycles after accept.
- **Signed, WIDTH=8:**
  - a=0x80 (-128), b=0x80 -> o=0x4000 (16384).
  - a=0xFD (-3), b=5 -> o=0xFFF1 (-15).
  - a=0x80, b=0x7F -> o=0xC080 (-16256).
- **Backpressure:** hold out_ready=0 for 6 cycles after out_valid.
  - Required: o and out_valid stable, in_ready=0, and a concurrent in_valid is ignored.
  - Then release out_ready: in_ready returns to 1 the next cycle.
- **Reset mid-RUN:** assert rst at RUN cycle 2.
  - Required: outputs are immediately IDLE values (o=0, out_valid=0, in_ready=1).
  - A subsequent 3*7 request gives o=21.
- **Zero and ignored inputs:** a=0, b=0xFF.
  - Required: o=0 with full latency.
  - Changing a and b during RUN does not alter the result.
- **Back-to-back random:** 1000 random operations, mixed signed_mode, random out_ready, at WIDTH=4, 8 and 16.
  - Compare against a golden behavioural product.
  - Check an initiation interval of WIDTH+2 when out_ready=1.
  - Check SIGNED_EN=0 treats signed_mode=1 as unsigned.
